// File: rtl/audio_buffer_ring.sv
// Ring of NUM_BUFFERS audio buffers between a committing producer and a four-phase consumer.
// Optional underrun/overflow statistics are enabled by defining AUDIO_BUFFER_RING_STATS_EN.
module audio_buffer_ring #(
    parameter int unsigned NUM_BUFFERS      = 4,
    parameter int unsigned BUFFER_ADDR_BITS = 9,
    parameter int unsigned LOW_WATERMARK    = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [BUFFER_ADDR_BITS-1:0]                     wr_addr_i,
    input  logic                                            wr_commit_i,
    output logic                                            wr_full_o,
    output logic [BUFFER_ADDR_BITS+$clog2(NUM_BUFFERS)-1:0] ram_wr_addr_o,
    input  logic [BUFFER_ADDR_BITS-1:0]                     rd_addr_i,
    input  logic                                            rd_empty_i,
    output logic                                            rd_empty_ack_o,
    output logic                                            rd_valid_o,
    output logic [BUFFER_ADDR_BITS+$clog2(NUM_BUFFERS)-1:0] ram_rd_addr_o,
    output logic [$clog2(NUM_BUFFERS):0]                    fill_level_o,
    output logic                                            buffer_low_o,
    output logic [15:0]                                     underrun_cnt_o,
    output logic                                            overflow_o
);
    localparam int unsigned IdxW = $clog2(NUM_BUFFERS);
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [CntW-1:0] NumBuf = CntW'(NUM_BUFFERS);
    localparam logic [CntW-1:0] LowWm  = CntW'(LOW_WATERMARK);

    typedef enum logic [1:0] {RIdle, RWait, RAck} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              playing_q, playing_d;
    logic              rel;
    logic              accept;

    // A buffer is released only when the consumer asks for a new one while holding one.
    assign rel    = (state_q == RIdle) & rd_empty_i & playing_q;
    assign accept = wr_commit_i & ((count_q < NumBuf) | rel);

    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        count_d   = count_q;
        playing_d = playing_q;
        state_d   = state_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            count_d  = count_d + 1'b1;
        end
        if (rel) begin
            rd_idx_d  = rd_idx_q + 1'b1;
            count_d   = count_d - 1'b1;
            playing_d = 1'b0;
        end
        unique case (state_q)
            RIdle: begin
                if (rd_empty_i) begin
                    if (count_d != '0) begin
                        state_d   = RAck;
                        playing_d = 1'b1;
                    end else begin
                        state_d = RWait;
                    end
                end
            end
            RWait: begin
                if (count_q != '0) begin
                    state_d   = RAck;
                    playing_d = 1'b1;
                end
            end
            RAck: begin
                if (!rd_empty_i) state_d = RIdle;
            end
            default: state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RIdle;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            count_q   <= '0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            count_q   <= count_d;
            playing_q <= playing_d;
        end
    end

    assign wr_full_o      = (count_q == NumBuf);
    assign fill_level_o   = count_q;
    assign buffer_low_o   = (count_q <= LowWm);
    assign rd_valid_o     = playing_q;
    assign rd_empty_ack_o = (state_q == RAck);
    assign ram_wr_addr_o  = {wr_idx_q, wr_addr_i};
    assign ram_rd_addr_o  = {rd_idx_q, rd_addr_i};

`ifdef AUDIO_BUFFER_RING_STATS_EN
    logic [15:0] underrun_q, underrun_d;
    logic        overflow_q, overflow_d;

    always_comb begin
        underrun_d = underrun_q;
        if ((state_q == RIdle) && (state_d == RWait) && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
        overflow_d = overflow_q | (wr_commit_i & ~accept);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign underrun_cnt_o = underrun_q;
    assign overflow_o     = overflow_q;
`else
    assign underrun_cnt_o = '0;
    assign overflow_o     = 1'b0;
`endif

endmodule

// File: doc/audio_buffer_ring.md
AUDIO_BUFFER_RING -- requirements
Module: audio_buffer_ring

Interface
REQ-001 Parameter NUM_BUFFERS, default 4, number of ring buffers (power of two, 2..16).
REQ-002 Parameter BUFFER_ADDR_BITS, default 9, byte address width within one buffer.
REQ-003 Parameter LOW_WATERMARK, default 1, fill level at or below which buffer_low_o asserts.
REQ-004 Port clk input 1: sole clock, all state updates on rising edge.
REQ-005 Port rst_n input 1: reset, synchronous, active-low.
REQ-006 Port wr_addr_i input BUFFER_ADDR_BITS: producer byte address within current write buffer.
REQ-007 Port wr_commit_i input 1: one-cycle pulse, current write buffer filled.
REQ-008 Port wr_full_o output 1: no free buffer.
REQ-009 Port ram_wr_addr_o output BUFFER_ADDR_BITS+log2(NUM_BUFFERS): {wr_idx, wr_addr_i}.
REQ-010 Port rd_addr_i input BUFFER_ADDR_BITS: consumer byte address within current read buffer.
REQ-011 Port rd_empty_i input 1: consumer level request, current buffer consumed, next wanted.
REQ-012 Port rd_empty_ack_o output 1: four-phase acknowledge, next buffer selected and valid.
REQ-013 Port rd_valid_o output 1: consumer holds a filled buffer.
REQ-014 Port ram_rd_addr_o output BUFFER_ADDR_BITS+log2(NUM_BUFFERS): {rd_idx, rd_addr_i}.
REQ-015 Port fill_level_o output log2(NUM_BUFFERS)+1: filled-buffer count, including the one being played.
REQ-016 Port buffer_low_o output 1: fill_level_o <= LOW_WATERMARK.
REQ-017 Port underrun_cnt_o output 16: saturating underrun count.
REQ-018 Port overflow_o output 1: sticky, commit attempted while full.

Function
REQ-019 State: wr_idx, rd_idx (mod NUM_BUFFERS, wrap N-1 -> 0), count (0..N), playing flag, FSM {R_IDLE, R_WAIT, R_ACK}.
REQ-020 wr_full_o = (count == NUM_BUFFERS); fill_level_o = count; address outputs combinational from registered indices.
REQ-021 release = (state R_IDLE) & rd_empty_i & playing; release advances rd_idx, decrements count, and clears playing.
REQ-022 Commit accepted if wr_commit_i & (count < N or release); accepted commit advances wr_idx and increments count.
REQ-023 Commit with count == N and no same-cycle release is ignored; it sets overflow_o.
REQ-024 Same-cycle accepted commit and release leave count unchanged and advance both indices.
REQ-025 R_IDLE & rd_empty_i: next = count - release + accepted commit; if next > 0 -> R_ACK, playing=1; else -> R_WAIT.
REQ-026 R_WAIT -> R_ACK with playing=1 on the first cycle where registered count > 0.
REQ-027 rd_empty_ack_o is 1 exactly while in R_ACK; it is registered, one-cycle latency from request when a buffer is available.
REQ-028 R_ACK -> R_IDLE on rd_empty_i == 0; rd_empty_i still high stays in R_ACK; no second release per request.
REQ-029 rd_valid_o = playing; playing buffer occupies rd_idx and is never overwritten (count includes it).
REQ-030 Initial request with playing=0 releases nothing; first filled buffer is handed to consumer.
REQ-031 rd_empty_i deasserted in R_WAIT: stay in R_WAIT; protocol violation, no special handling.

Reset
REQ-032 rst_n low at clock edge: wr_idx=0, rd_idx=0, count=0, playing=0, state R_IDLE, rd_empty_ack_o=0, underrun_cnt_o=0, overflow_o=0.
REQ-033 Reset mid-operation discards all filled buffers; wr_full_o=0, buffer_low_o=1, rd_valid_o=0 after the edge.

Configuration
REQ-034 Macro AUDIO_BUFFER_RING_STATS_EN defined: underrun_cnt_o increments once per R_IDLE->R_WAIT transition, saturating at 16'hFFFF; overflow_o operates per REQ-023.
REQ-035 Macro undefined: underrun_cnt_o and overflow_o are tied to 0; no counter logic; all other behaviour is identical.

Verification
REQ-036 N=4: 4 commits, no requests -> fill_level_o=4, wr_full_o=1; 5th commit ignored, overflow_o=1 (STATS_EN).
REQ-037 count=2, playing=0: rd_empty_i rises -> ack next cycle, rd_valid_o=1, count=2, rd_idx=0; rd_empty_i falls -> ack falls next cycle.
REQ-038 count=1, playing=1: request -> release, R_WAIT, underrun_cnt_o=1; commit 3 cycles later -> ack the cycle after count=1.
REQ-039 count=4 full, playing=1: commit and request in same cycle -> both accepted, count=4, wr_idx and rd_idx both advance; indices wrap 3->0.
REQ-040 Full ring, state R_ACK: rst_n low one cycle -> count=0, ack=0, indices 0, stats cleared.
REQ-041 Without AUDIO_BUFFER_RING_STATS_EN: run REQ-038 stimulus -> underrun_cnt_o stays 0, handshake identical.
